// File: rtl/uram_port_arbiter_if.sv
// rtl/uram_port_arbiter_if.sv - requester-side request/response bundle for uram_port_arbiter
//
// Purpose: groups both requesters' request and response signals (p0 = core
// datapath, p1 = host/loader) so they travel as one port.
// Signals (per requester pN):
//   pN_req_valid  requester -> arbiter  request present
//   pN_req_ready  arbiter -> requester  request accepted this cycle
//   pN_req_we     requester -> arbiter  1 = write, 0 = read
//   pN_req_addr   requester -> arbiter  word address
//   pN_req_wdata  requester -> arbiter  write data
//   pN_rsp_valid  arbiter -> requester  read data valid, one cycle after read accept
//   pN_rsp_data   arbiter -> requester  read data
// Modports: master = requester side, slave = arbiter side.
interface uram_port_arbiter_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12
);
    logic                     p0_req_valid;
    logic                     p0_req_ready;
    logic                     p0_req_we;
    logic [ADDRESS_WIDTH-1:0] p0_req_addr;
    logic [DATA_WIDTH-1:0]    p0_req_wdata;
    logic                     p0_rsp_valid;
    logic [DATA_WIDTH-1:0]    p0_rsp_data;

    logic                     p1_req_valid;
    logic                     p1_req_ready;
    logic                     p1_req_we;
    logic [ADDRESS_WIDTH-1:0] p1_req_addr;
    logic [DATA_WIDTH-1:0]    p1_req_wdata;
    logic                     p1_rsp_valid;
    logic [DATA_WIDTH-1:0]    p1_rsp_data;

    modport master (
        output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_data,
        output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_data
    );

    modport slave (
        input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
        output p0_req_ready, p0_rsp_valid, p0_rsp_data,
        input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
        output p1_req_ready, p1_rsp_valid, p1_rsp_data
    );
endinterface

// File: rtl/uram_port_arbiter.sv
// rtl/uram_port_arbiter.sv - two-requester round-robin arbiter and zero-fill sequencer for a URAM macro
//
// Purpose: shares one memory (1 read port, 1 write port, 1-cycle registered
// read, write-first) between two requesters. Read and write ports are
// arbitrated independently with separate round-robin pointers. A clear
// sequencer zero-fills the whole array, one word per cycle.
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   clear_start           pulse: begin zero-fill (ignored while a clear runs)
//   clear_busy            high while zero-fill in progress
//   clear_done            1-cycle pulse after the last clear write
//   bus                   requester request/response bundle (slave side)
//   mem_raddr, mem_dout   memory read address / registered read data
//   mem_wen, mem_waddr,
//   mem_din               memory write port
module uram_port_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     clear_done,
    uram_port_arbiter_if.slave       bus,
    output logic [ADDRESS_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]    mem_dout,
    output logic                     mem_wen,
    output logic [ADDRESS_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]    mem_din
);
    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clear_cnt_q;
    logic                     clear_done_q;
    logic                     wr_ptr_q;      // 0: p0 wins next contended write
    logic                     rd_ptr_q;      // 0: p0 wins next contended read
    logic                     rsp0_q, rsp1_q;
    logic [ADDRESS_WIDTH-1:0] raddr_q;

    logic arb_en;
    logic wc0, wc1, rc0, rc1;
    logic wg0, wg1, rg0, rg1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_start) state_d = ST_CLEAR;
            ST_CLEAR: if (clear_cnt_q == LAST_ADDR) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Grants are gated by reset so ready reads 0 during the reset cycle itself.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    assign wc0 = arb_en && bus.p0_req_valid &&  bus.p0_req_we;
    assign wc1 = arb_en && bus.p1_req_valid &&  bus.p1_req_we;
    assign rc0 = arb_en && bus.p0_req_valid && !bus.p0_req_we;
    assign rc1 = arb_en && bus.p1_req_valid && !bus.p1_req_we;

    assign wg0 = wc0 && (!wc1 || !wr_ptr_q);
    assign wg1 = wc1 && (!wc0 ||  wr_ptr_q);
    assign rg0 = rc0 && (!rc1 || !rd_ptr_q);
    assign rg1 = rc1 && (!rc0 ||  rd_ptr_q);

    always_comb begin
        clear_busy       = (state_q == ST_CLEAR);
        clear_done       = clear_done_q;
        bus.p0_req_ready = wg0 || rg0;
        bus.p1_req_ready = wg1 || rg1;
        bus.p0_rsp_valid = rsp0_q;
        bus.p1_rsp_valid = rsp1_q;
        bus.p0_rsp_data  = mem_dout;
        bus.p1_rsp_data  = mem_dout;
        mem_wen          = clear_busy || wg0 || wg1;
        mem_waddr        = bus.p0_req_addr;
        mem_din          = bus.p0_req_wdata;
        if (clear_busy) begin
            mem_waddr = clear_cnt_q;
            mem_din   = '0;
        end else if (wg1) begin
            mem_waddr = bus.p1_req_addr;
            mem_din   = bus.p1_req_wdata;
        end
        // Without a read grant the read address simply parks on its last value.
        mem_raddr = raddr_q;
        if (rg0)      mem_raddr = bus.p0_req_addr;
        else if (rg1) mem_raddr = bus.p1_req_addr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clear_cnt_q  <= '0;
            clear_done_q <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            raddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            // Counter wraps back to 0 on the last clear write.
            clear_cnt_q  <= clear_busy ? clear_cnt_q + 1'b1 : '0;
            clear_done_q <= clear_busy && (clear_cnt_q == LAST_ADDR);
            // Pointers only hand priority over after a contended grant.
            if (wc0 && wc1) wr_ptr_q <= !wr_ptr_q;
            if (rc0 && rc1) rd_ptr_q <= !rd_ptr_q;
            rsp0_q       <= rg0;
            rsp1_q       <= rg1;
            raddr_q      <= mem_raddr;
        end
    end
endmodule

// File: tb/tb_uram_port_arbiter.sv
// tb/tb_uram_port_arbiter.sv - directed and random self-checking bench for uram_port_arbiter
module tb_uram_port_arbiter;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_din;

    int n_cmp = 0;
    int n_bad = 0;

    uram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) req_bus ();

    uram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .bus         (req_bus),
        .mem_raddr   (mem_raddr),
        .mem_dout    (mem_dout),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_din     (mem_din)
    );

    always #5 clock = ~clock;

    // Memory macro: registered read, write-first on same-address collision.
    logic [DW-1:0] mem_array [DEPTH];
    always @(posedge clock) begin
        if (mem_wen) mem_array[mem_waddr] <= mem_din;
        mem_dout <= (mem_wen && mem_waddr == mem_raddr) ? mem_din : mem_array[mem_raddr];
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        clear_start          = 1'b0;
        req_bus.p0_req_valid = 1'b0;
        req_bus.p0_req_we    = 1'b0;
        req_bus.p0_req_addr  = '0;
        req_bus.p0_req_wdata = '0;
        req_bus.p1_req_valid = 1'b0;
        req_bus.p1_req_we    = 1'b0;
        req_bus.p1_req_addr  = '0;
        req_bus.p1_req_wdata = '0;
    endtask

    task automatic drive_p0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_bus.p0_req_valid = v;
        req_bus.p0_req_we    = we;
        req_bus.p0_req_addr  = a;
        req_bus.p0_req_wdata = d;
    endtask

    task automatic drive_p1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_bus.p1_req_valid = v;
        req_bus.p1_req_we    = we;
        req_bus.p1_req_addr  = a;
        req_bus.p1_req_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Random-traffic state, one entry per requester.
    logic          act  [2];
    logic          rwe  [2];
    logic [AW-1:0] radr [2];
    logic [DW-1:0] rdat [2];
    int            waitc[2];
    logic          pend [2];
    logic [DW-1:0] expd [2];
    logic          rdy  [2];
    logic          rv   [2];
    logic [DW-1:0] rd   [2];
    logic [DW-1:0] shadow [DEPTH];

    initial begin
        reset = 1'b1;
        drive_idle();
        drive_p0(1'b1, 1'b0, 4'd0, '0);

        // Reset state
        next_cycle();
        @(negedge clock);
        check_eq("rst_busy", clear_busy, 0);
        check_eq("rst_done", clear_done, 0);
        check_eq("rst_wen", mem_wen, 0);
        check_eq("rst_p0_ready", req_bus.p0_req_ready, 0);
        check_eq("rst_p0_rsp", req_bus.p0_rsp_valid, 0);
        check_eq("rst_p1_rsp", req_bus.p1_rsp_valid, 0);
        next_cycle();
        reset = 1'b0;
        drive_idle();

        // 1: write then read back on p0
        next_cycle();
        drive_p0(1'b1, 1'b1, 4'd5, 64'hAA);
        @(negedge clock);
        check_eq("t1_wr_ready", req_bus.p0_req_ready, 1);
        check_eq("t1_wen", mem_wen, 1);
        check_eq("t1_waddr", mem_waddr, 5);
        check_eq("t1_din", mem_din, 64'hAA);
        check_eq("t1_p1_ready", req_bus.p1_req_ready, 0);
        next_cycle();
        drive_p0(1'b1, 1'b0, 4'd5, '0);
        @(negedge clock);
        check_eq("t1_rd_ready", req_bus.p0_req_ready, 1);
        check_eq("t1_raddr", mem_raddr, 5);
        check_eq("t1_rd_wen", mem_wen, 0);
        check_eq("t1_no_early_rsp", req_bus.p0_rsp_valid, 0);
        next_cycle();
        drive_idle();
        @(negedge clock);
        check_eq("t1_rsp_valid", req_bus.p0_rsp_valid, 1);
        check_eq("t1_rsp_data", req_bus.p0_rsp_data, 64'hAA);
        check_eq("t1_p1_rsp", req_bus.p1_rsp_valid, 0);
        next_cycle();
        @(negedge clock);
        check_eq("t1_rsp_oneshot", req_bus.p0_rsp_valid, 0);

        // 2: contending writes then contending reads alternate p0,p1,p0,p1
        next_cycle();
        drive_p0(1'b1, 1'b1, 4'd1, 64'h101);
        drive_p1(1'b1, 1'b1, 4'd2, 64'h202);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_eq("t2_wr_p0_ready", req_bus.p0_req_ready, (k % 2) == 0);
            check_eq("t2_wr_p1_ready", req_bus.p1_req_ready, (k % 2) == 1);
            check_eq("t2_waddr", mem_waddr, ((k % 2) == 0) ? 1 : 2);
            check_eq("t2_din", mem_din, ((k % 2) == 0) ? 64'h101 : 64'h202);
            next_cycle();
        end
        drive_p0(1'b1, 1'b0, 4'd1, '0);
        drive_p1(1'b1, 1'b0, 4'd2, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_eq("t2_rd_p0_ready", req_bus.p0_req_ready, (k % 2) == 0);
            check_eq("t2_rd_p1_ready", req_bus.p1_req_ready, (k % 2) == 1);
            check_eq("t2_raddr", mem_raddr, ((k % 2) == 0) ? 1 : 2);
            if (k > 0) begin
                check_eq("t2_p0_rsp", req_bus.p0_rsp_valid, (k % 2) == 1);
                check_eq("t2_p1_rsp", req_bus.p1_rsp_valid, (k % 2) == 0);
                check_eq("t2_rsp_data", req_bus.p0_rsp_data, ((k % 2) == 1) ? 64'h101 : 64'h202);
            end
            next_cycle();
        end
        drive_idle();
        @(negedge clock);
        check_eq("t2_last_p1_rsp", req_bus.p1_rsp_valid, 1);
        check_eq("t2_last_p0_rsp", req_bus.p0_rsp_valid, 0);
        check_eq("t2_last_data", req_bus.p1_rsp_data, 64'h202);

        // 3: same-cycle write and read of one address returns the new data
        next_cycle();
        drive_p0(1'b1, 1'b1, 4'd7, 64'h11);
        drive_p1(1'b1, 1'b0, 4'd7, '0);
        @(negedge clock);
        check_eq("t3_p0_ready", req_bus.p0_req_ready, 1);
        check_eq("t3_p1_ready", req_bus.p1_req_ready, 1);
        next_cycle();
        drive_idle();
        @(negedge clock);
        check_eq("t3_p1_rsp", req_bus.p1_rsp_valid, 1);
        check_eq("t3_p1_data", req_bus.p1_rsp_data, 64'h11);
        check_eq("t3_p0_rsp", req_bus.p0_rsp_valid, 0);

        // 4: full clear, requests stalled, second clear_start ignored
        next_cycle();
        clear_start = 1'b1;
        @(negedge clock);
        check_eq("t4_busy_before", clear_busy, 0);
        next_cycle();
        clear_start = 1'b0;
        drive_p0(1'b1, 1'b0, 4'd3, '0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            check_eq("t4_busy", clear_busy, 1);
            check_eq("t4_wen", mem_wen, 1);
            check_eq("t4_waddr", mem_waddr, i);
            check_eq("t4_din", mem_din, 0);
            check_eq("t4_ready_blocked", req_bus.p0_req_ready, 0);
            check_eq("t4_done_early", clear_done, 0);
            next_cycle();
            clear_start = (i == 7);
        end
        clear_start = 1'b0;
        @(negedge clock);
        check_eq("t4_busy_end", clear_busy, 0);
        check_eq("t4_done", clear_done, 1);
        check_eq("t4_ready_after", req_bus.p0_req_ready, 1);
        check_eq("t4_wen_end", mem_wen, 0);
        next_cycle();
        drive_idle();
        @(negedge clock);
        check_eq("t4_done_pulse", clear_done, 0);
        check_eq("t4_rsp_valid", req_bus.p0_rsp_valid, 1);
        check_eq("t4_rsp_zero", req_bus.p0_rsp_data, 0);

        // 5: reset mid-clear aborts, then a new clear starts from 0
        next_cycle();
        clear_start = 1'b1;
        next_cycle();
        clear_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("t5_waddr", mem_waddr, i);
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clock);
        check_eq("t5_busy_at_rst", clear_busy, 1);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_eq("t5_busy_abort", clear_busy, 0);
        check_eq("t5_wen_abort", mem_wen, 0);
        check_eq("t5_no_done", clear_done, 0);
        next_cycle();
        @(negedge clock);
        check_eq("t5_no_done_late", clear_done, 0);
        next_cycle();
        clear_start = 1'b1;
        next_cycle();
        clear_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            check_eq("t5_busy", clear_busy, 1);
            check_eq("t5_restart_waddr", mem_waddr, i);
            next_cycle();
        end
        @(negedge clock);
        check_eq("t5_done", clear_done, 1);

        // 6: random mixed traffic against a shadow memory (array is all zero now)
        for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; pend[p] = 1'b0; waitc[p] = 0;
            rwe[p] = 1'b0; radr[p] = '0; rdat[p] = '0; expd[p] = '0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            next_cycle();
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && $urandom_range(0, 9) < 6) begin
                    act[p]   = 1'b1;
                    rwe[p]   = 1'($urandom_range(0, 1));
                    radr[p]  = AW'($urandom_range(0, DEPTH - 1));
                    rdat[p]  = {$urandom, $urandom};
                    waitc[p] = 0;
                end
            end
            drive_p0(act[0], rwe[0], radr[0], rdat[0]);
            drive_p1(act[1], rwe[1], radr[1], rdat[1]);
            @(negedge clock);
            rdy[0] = req_bus.p0_req_ready;  rdy[1] = req_bus.p1_req_ready;
            rv[0]  = req_bus.p0_rsp_valid;  rv[1]  = req_bus.p1_rsp_valid;
            rd[0]  = req_bus.p0_rsp_data;   rd[1]  = req_bus.p1_rsp_data;
            for (int p = 0; p < 2; p++) begin
                check_eq("t6_rsp_valid", rv[p], pend[p]);
                if (pend[p]) check_eq("t6_rsp_data", rd[p], expd[p]);
                check_eq("t6_ready_no_req", rdy[p] && !act[p], 0);
            end
            check_eq("t6_dual_write", rdy[0] && act[0] && rwe[0] && rdy[1] && act[1] && rwe[1], 0);
            for (int p = 0; p < 2; p++)
                if (rdy[p] && act[p] && rwe[p]) shadow[radr[p]] = rdat[p];
            for (int p = 0; p < 2; p++) begin
                pend[p] = rdy[p] && act[p] && !rwe[p];
                if (pend[p]) expd[p] = shadow[radr[p]];
                if (act[p]) begin
                    if (rdy[p]) begin
                        check_eq("t6_grant_wait", waitc[p] <= 1, 1);
                        act[p] = 1'b0;
                    end else begin
                        waitc[p]++;
                        if (waitc[p] == 3) check_eq("t6_starved", waitc[p], 1);
                    end
                end
            end
        end
        next_cycle();
        drive_idle();
        @(negedge clock);
        check_eq("t6_tail_p0", req_bus.p0_rsp_valid, pend[0]);
        check_eq("t6_tail_p1", req_bus.p1_rsp_valid, pend[1]);
        if (pend[0]) check_eq("t6_tail_d0", req_bus.p0_rsp_data, expd[0]);
        if (pend[1]) check_eq("t6_tail_d1", req_bus.p1_rsp_data, expd[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
